// File: rtl/fft_frame_collector.sv
// fft_frame_collector
//
// Capture buffer between the FFT output stream and the host read port.
// Every valid bin advances a free-running bin index. The first BINS bins of a
// frame are stored, together with the channel tag sampled at bin 0. The block
// then raises frame_rdy and a one-cycle irq, and the host drains the frame one
// word per rd_strobe. A frame whose bin 0 arrives while the buffer is still
// held is dropped whole, and ovr_cnt counts it.
//
// Build option: FFT_COLLECTOR_MAG_EN
//   defined     - magnitude estimator present; mag_sel (sampled at bin 0)
//                 selects {chan, max+min/2} words instead of raw {im, re}.
//   not defined - words are always raw {im, re}; mag_sel is ignored.
//
// Ports
//   clk, rstb         clock (rising edge), async active-low reset
//   enable            allows a new capture to start at bin 0
//   chan              channel of the streaming frame, sampled at bin 0
//   fft_datao_valid   bin strobe; fft_re / fft_im signed bin value
//   mag_sel           word format select, sampled at bin 0
//   rd_strobe         host pop request
//   rd_data/rd_valid  popped word and its one-cycle valid
//   frame_rdy         a complete frame is held
//   irq               one-cycle pulse when frame_rdy rises
//   frame_chan        channel tag of the held frame
//   ovr_cnt           saturating dropped-frame count

module fft_frame_collector #(
    parameter int DATA_W = 16,
    parameter int POINTS = 512,
    parameter int BINS   = 256,
    parameter int CHAN_W = 6
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  enable,
    input  logic [CHAN_W-1:0]     chan,
    input  logic                  fft_datao_valid,
    input  logic [DATA_W-1:0]     fft_re,
    input  logic [DATA_W-1:0]     fft_im,
    input  logic                  mag_sel,
    input  logic                  rd_strobe,
    output logic [2*DATA_W-1:0]   rd_data,
    output logic                  rd_valid,
    output logic                  frame_rdy,
    output logic                  irq,
    output logic [CHAN_W-1:0]     frame_chan,
    output logic [7:0]            ovr_cnt
);

    // state     | meaning
    // ----------+-----------------------------------------------------
    // S_IDLE    | buffer free, waiting for bin 0 with enable high
    // S_CAPTURE | storing bins 0..BINS-1, discarding the rest
    // S_DONE    | last bin seen; lets the final write land before ready
    // S_READY   | frame held, host drains it with rd_strobe

    localparam int IDX_W  = $clog2(POINTS);
    localparam int PTR_W  = (BINS > 1) ? $clog2(BINS) : 1;
    localparam int KEEP_W = IDX_W + 1;
    localparam int TAG_W  = DATA_W - 1;
    localparam int WORD_W = 2 * DATA_W;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(POINTS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(BINS - 1);
    localparam logic [KEEP_W-1:0] KEEP_LIM = KEEP_W'(BINS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE,
        S_READY
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CHAN_W-1:0]   cap_chan_q;

    // write stage: one register between the input bin and the buffer
    logic                wr_en_q;
    logic [PTR_W-1:0]    wr_addr_q;
    logic [DATA_W-1:0]   re_q, im_q;
    logic [WORD_W-1:0]   wr_word;

    logic                bin0, last_bin, keep_bin;
    logic                start, wr_en_d, pop, drop;

    logic [WORD_W-1:0]   mem [BINS];

    assign frame_rdy = (state_q == S_READY);

    always_comb begin
        bin0     = fft_datao_valid && (idx_q == '0);
        last_bin = fft_datao_valid && (idx_q == LAST_IDX);
        keep_bin = fft_datao_valid && ({1'b0, idx_q} < KEEP_LIM);
        state_d  = state_q;
        start    = 1'b0;
        wr_en_d  = 1'b0;
        pop      = 1'b0;
        // the buffer only becomes free the cycle after the final pop, so a
        // bin 0 on that cycle is still dropped
        drop     = bin0 && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (bin0 && enable) begin
                    start   = 1'b1;
                    wr_en_d = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                wr_en_d = keep_bin;
                if (last_bin) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_READY;
            end
            S_READY: begin
                if (rd_strobe) begin
                    pop = 1'b1;
                    if (rd_ptr_q == LAST_PTR) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef FFT_COLLECTOR_MAG_EN
    logic              cap_mag_q;
    logic [DATA_W-1:0] abs_re, abs_im, big, small;
    logic [DATA_W:0]   mag;

    // abs of the most negative value is exact as an unsigned DATA_W number
    always_comb begin
        abs_re  = re_q[DATA_W-1] ? (~re_q + 1'b1) : re_q;
        abs_im  = im_q[DATA_W-1] ? (~im_q + 1'b1) : im_q;
        big     = (abs_re >= abs_im) ? abs_re : abs_im;
        small   = (abs_re >= abs_im) ? abs_im : abs_re;
        mag     = {1'b0, big} + {2'b00, small[DATA_W-1:1]};
        wr_word = cap_mag_q ? {TAG_W'(cap_chan_q), mag} : {im_q, re_q};
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cap_mag_q <= 1'b0;
        end else if (start) begin
            cap_mag_q <= mag_sel;
        end
    end
`else
    logic mag_sel_unused;
    assign mag_sel_unused = mag_sel;

    always_comb begin
        wr_word = {im_q, re_q};
    end
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rd_ptr_q   <= '0;
            ovr_cnt    <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            irq        <= 1'b0;
            frame_chan <= '0;
            cap_chan_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            re_q       <= '0;
            im_q       <= '0;
        end else begin
            state_q  <= state_d;
            irq      <= (state_q == S_DONE);
            rd_valid <= pop;
            wr_en_q  <= wr_en_d;
            // idx wraps naturally since POINTS is a power of two
            if (fft_datao_valid) begin
                idx_q     <= idx_q + 1'b1;
                wr_addr_q <= idx_q[PTR_W-1:0];
                re_q      <= fft_re;
                im_q      <= fft_im;
            end
            if (start) begin
                cap_chan_q <= chan;
            end
            // tag becomes visible together with the write of bin 0
            if (wr_en_q && (wr_addr_q == '0)) begin
                frame_chan <= cap_chan_q;
            end
            if (pop) begin
                rd_data  <= mem[rd_ptr_q];
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            if (drop && (ovr_cnt != 8'hFF)) begin
                ovr_cnt <= ovr_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_q) begin
            mem[wr_addr_q] <= wr_word;
        end
    end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Testbench for fft_frame_collector at default parameters
// (DATA_W=16, POINTS=512, BINS=256, CHAN_W=6). Works in both builds;
// expectations for the magnitude frame follow FFT_COLLECTOR_MAG_EN.

module tb_fft_frame_collector;

    localparam int POINTS = 512;
    localparam int BINS   = 256;

    logic        clk;
    logic        rstb;
    logic        enable;
    logic [5:0]  chan;
    logic        fft_datao_valid;
    logic [15:0] fft_re, fft_im;
    logic        mag_sel;
    logic        rd_strobe;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        frame_rdy;
    logic        irq;
    logic [5:0]  frame_chan;
    logic [7:0]  ovr_cnt;

    int checks;
    int failures;

    fft_frame_collector dut (
        .clk             (clk),
        .rstb            (rstb),
        .enable          (enable),
        .chan            (chan),
        .fft_datao_valid (fft_datao_valid),
        .fft_re          (fft_re),
        .fft_im          (fft_im),
        .mag_sel         (mag_sel),
        .rd_strobe       (rd_strobe),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .frame_rdy       (frame_rdy),
        .irq             (irq),
        .frame_chan      (frame_chan),
        .ovr_cnt         (ovr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: re=k, im=-k
    // mode 1: bin0 (-32768,-32768), bin1 (3,-8), else (k,-k)
    // mode 2: re=k+1000, im=7
    // mode 3: re=-1, im=-1
    function automatic logic [15:0] bin_re(input int mode, input int k);
        case (mode)
            0:       bin_re = 16'(k);
            1:       bin_re = (k == 0) ? 16'h8000 : (k == 1) ? 16'd3 : 16'(k);
            2:       bin_re = 16'(k + 1000);
            default: bin_re = 16'hFFFF;
        endcase
    endfunction

    function automatic logic [15:0] bin_im(input int mode, input int k);
        case (mode)
            0:       bin_im = 16'(-k);
            1:       bin_im = (k == 0) ? 16'h8000 : (k == 1) ? 16'hFFF8 : 16'(-k);
            2:       bin_im = 16'd7;
            default: bin_im = 16'hFFFF;
        endcase
    endfunction

    // expected buffer word; the mode 1 frame uses chan 7
    function automatic logic [31:0] exp_word(input int mode, input int k);
        case (mode)
            0: exp_word = {16'(-k), 16'(k)};
            1: begin
`ifdef FFT_COLLECTOR_MAG_EN
                if (k == 0)      exp_word = {15'd7, 17'd49152};
                else if (k == 1) exp_word = {15'd7, 17'd9};
                else             exp_word = {15'd7, 17'(k + k / 2)};
`else
                if (k == 0)      exp_word = 32'h8000_8000;
                else if (k == 1) exp_word = 32'hFFF8_0003;
                else             exp_word = {16'(-k), 16'(k)};
`endif
            end
            2:       exp_word = {16'd7, 16'(k + 1000)};
            default: exp_word = 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // streams bins first..last; chan/mag_sel carry the frame values only at
    // bin 0. With gaps, idle cycles carry rd_strobe and rd_valid is watched.
    task automatic send_frame(input int mode, input logic [5:0] ch, input logic msel,
                              input int first, input int last, input bit gaps,
                              output int gap_bad);
        int n;
        gap_bad = 0;
        for (int k = first; k <= last; k++) begin
            if (gaps) begin
                n = $urandom_range(7, 0);
                for (int g = 0; g < n; g++) begin
                    fft_datao_valid = 1'b0;
                    rd_strobe       = 1'b1;
                    tick();
                    if (rd_valid !== 1'b0) gap_bad++;
                end
                rd_strobe = 1'b0;
            end
            fft_datao_valid = 1'b1;
            fft_re  = bin_re(mode, k);
            fft_im  = bin_im(mode, k);
            chan    = (k == 0) ? ch : ~ch;
            mag_sel = (k == 0) ? msel : ~msel;
            tick();
        end
        fft_datao_valid = 1'b0;
        mag_sel         = 1'b0;
    endtask

    // pops n words and checks each; on a full drain checks frame_rdy falls.
    // overlap_last puts a mode-3 bin 0 on the final pop cycle.
    task automatic drain(input int mode, input int n, input bit overlap_last);
        for (int k = 0; k < n; k++) begin
            rd_strobe = 1'b1;
            if (overlap_last && k == BINS - 1) begin
                fft_datao_valid = 1'b1;
                fft_re = bin_re(3, 0);
                fft_im = bin_im(3, 0);
            end
            tick();
            rd_strobe       = 1'b0;
            fft_datao_valid = 1'b0;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_word(mode, k)) begin
                failures++;
                $display("FAIL drain_word mode=%0d k=%0d got valid=%b data=%h want valid=1 data=%h",
                         mode, k, rd_valid, rd_data, exp_word(mode, k));
            end
            if (k == BINS - 2) begin
                checks++;
                if (frame_rdy !== 1'b1) begin
                    failures++;
                    $display("FAIL rdy_before_last_pop got %b want 1", frame_rdy);
                end
            end
        end
        if (n == BINS) begin
            checks++;
            if (frame_rdy !== 1'b0) begin
                failures++;
                $display("FAIL rdy_after_last_pop got %b want 0", frame_rdy);
            end
        end
    endtask

    task automatic test_reset;
        rstb = 1'b0;
        tick();
        tick();
        checks++;
        if ({rd_data, rd_valid, frame_rdy, irq, frame_chan, ovr_cnt} !== 49'd0) begin
            failures++;
            $display("FAIL reset_outputs got %h want 0",
                     {rd_data, rd_valid, frame_rdy, irq, frame_chan, ovr_cnt});
        end
        #2 rstb = 1'b1;
        tick();
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_strobe_ignored got rd_valid=%b want 0", rd_valid);
        end
    endtask

    task automatic test_basic_frame;
        int gb;
        send_frame(0, 6'd5, 1'b0, 0, 0, 1'b0, gb);
        checks++;
        if (frame_chan !== 6'd0) begin
            failures++;
            $display("FAIL chan_before_write got %0d want 0", frame_chan);
        end
        send_frame(0, 6'd5, 1'b0, 1, 1, 1'b0, gb);
        checks++;
        if (frame_chan !== 6'd5) begin
            failures++;
            $display("FAIL chan_at_write got %0d want 5", frame_chan);
        end
        send_frame(0, 6'd5, 1'b0, 2, POINTS - 1, 1'b0, gb);
        checks++;
        if (frame_rdy !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL rdy_one_edge_after_last got rdy=%b irq=%b want 0 0", frame_rdy, irq);
        end
        tick();
        checks++;
        if (frame_rdy !== 1'b1 || irq !== 1'b1) begin
            failures++;
            $display("FAIL rdy_two_edges_after_last got rdy=%b irq=%b want 1 1", frame_rdy, irq);
        end
        tick();
        checks++;
        if (frame_rdy !== 1'b1 || irq !== 1'b0 || frame_chan !== 6'd5) begin
            failures++;
            $display("FAIL irq_one_cycle got rdy=%b irq=%b chan=%0d want 1 0 5",
                     frame_rdy, irq, frame_chan);
        end
        drain(0, BINS, 1'b0);
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'hFF01_00FF) begin
            failures++;
            $display("FAIL rd_data_hold got valid=%b data=%h want 0 ff0100ff", rd_valid, rd_data);
        end
    endtask

    task automatic test_magnitude;
        int gb;
        send_frame(1, 6'd7, 1'b1, 0, POINTS - 1, 1'b0, gb);
        tick();
        tick();
        checks++;
        if (frame_rdy !== 1'b1 || frame_chan !== 6'd7) begin
            failures++;
            $display("FAIL mag_frame_ready got rdy=%b chan=%0d want 1 7", frame_rdy, frame_chan);
        end
        drain(1, BINS, 1'b0);
    endtask

    task automatic test_overrun;
        int gb;
        send_frame(0, 6'd5, 1'b0, 0, POINTS - 1, 1'b0, gb);
        tick();
        tick();
        send_frame(2, 6'd9, 1'b0, 0, POINTS - 1, 1'b0, gb);
        checks++;
        if (ovr_cnt !== 8'd1 || frame_rdy !== 1'b1 || frame_chan !== 6'd5) begin
            failures++;
            $display("FAIL overrun_held got ovr=%0d rdy=%b chan=%0d want 1 1 5",
                     ovr_cnt, frame_rdy, frame_chan);
        end
        drain(0, BINS, 1'b1);
        checks++;
        if (ovr_cnt !== 8'd2) begin
            failures++;
            $display("FAIL overrun_final_pop got ovr=%0d want 2", ovr_cnt);
        end
        send_frame(3, 6'd9, 1'b0, 1, POINTS - 1, 1'b0, gb);
        tick();
        tick();
        checks++;
        if (frame_rdy !== 1'b0 || ovr_cnt !== 8'd2) begin
            failures++;
            $display("FAIL dropped_not_captured got rdy=%b ovr=%0d want 0 2", frame_rdy, ovr_cnt);
        end
        send_frame(2, 6'd9, 1'b0, 0, POINTS - 1, 1'b0, gb);
        tick();
        tick();
        checks++;
        if (frame_rdy !== 1'b1 || frame_chan !== 6'd9) begin
            failures++;
            $display("FAIL next_frame_captured got rdy=%b chan=%0d want 1 9", frame_rdy, frame_chan);
        end
        drain(2, BINS, 1'b0);
    endtask

    task automatic test_gaps;
        int gb;
        send_frame(0, 6'd12, 1'b0, 0, POINTS - 1, 1'b1, gb);
        checks++;
        if (gb !== 0) begin
            failures++;
            $display("FAIL gap_rd_valid got %0d cycles with rd_valid want 0", gb);
        end
        tick();
        tick();
        checks++;
        if (frame_rdy !== 1'b1 || frame_chan !== 6'd12) begin
            failures++;
            $display("FAIL gap_frame_ready got rdy=%b chan=%0d want 1 12", frame_rdy, frame_chan);
        end
        drain(0, BINS, 1'b0);
    endtask

    task automatic test_reset_mid;
        int gb;
        send_frame(0, 6'd3, 1'b0, 0, 99, 1'b0, gb);
        #2 rstb = 1'b0;
        #1;
        checks++;
        if ({rd_data, rd_valid, frame_rdy, irq, frame_chan, ovr_cnt} !== 49'd0) begin
            failures++;
            $display("FAIL reset_mid_capture got %h want 0",
                     {rd_data, rd_valid, frame_rdy, irq, frame_chan, ovr_cnt});
        end
        tick();
        #2 rstb = 1'b1;
        tick();
        send_frame(2, 6'd11, 1'b0, 0, POINTS - 1, 1'b0, gb);
        tick();
        tick();
        checks++;
        if (frame_rdy !== 1'b1 || frame_chan !== 6'd11) begin
            failures++;
            $display("FAIL after_reset_capture got rdy=%b chan=%0d want 1 11", frame_rdy, frame_chan);
        end
        drain(2, 40, 1'b0);
        #2 rstb = 1'b0;
        #1;
        checks++;
        if ({rd_data, rd_valid, frame_rdy, irq, frame_chan, ovr_cnt} !== 49'd0) begin
            failures++;
            $display("FAIL reset_mid_drain got %h want 0",
                     {rd_data, rd_valid, frame_rdy, irq, frame_chan, ovr_cnt});
        end
        tick();
        #2 rstb = 1'b1;
        tick();
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || frame_rdy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got valid=%b rdy=%b want 0 0", rd_valid, frame_rdy);
        end
        send_frame(0, 6'd20, 1'b0, 0, POINTS - 1, 1'b0, gb);
        tick();
        tick();
        checks++;
        if (frame_rdy !== 1'b1 || frame_chan !== 6'd20) begin
            failures++;
            $display("FAIL recapture got rdy=%b chan=%0d want 1 20", frame_rdy, frame_chan);
        end
        drain(0, BINS, 1'b0);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rstb            = 1'b0;
        enable          = 1'b1;
        chan            = '0;
        fft_datao_valid = 1'b0;
        fft_re          = '0;
        fft_im          = '0;
        mag_sel         = 1'b0;
        rd_strobe       = 1'b0;

        test_reset();
        test_basic_frame();
        test_magnitude();
        test_overrun();
        test_gaps();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_collector.md
# fft_frame_collector

Parametrised capture buffer between the FFT core's output stream and the host read port. It counts every output bin of each FFT frame and stores the first `BINS` bins of a frame in an internal buffer, tagged with the channel that produced them. It then raises a ready flag and a one-cycle interrupt, and drains the frame word-by-word on host read strobes. Frames that arrive while the buffer is still held are dropped whole and counted. This block replaces the fixed 512-point, single-width output FIFO path.

## Interface
Parameters:
- `DATA_W`, 16: width of the signed FFT real and imaginary outputs.
- `POINTS`, 512: FFT frame length; power of two, ≥ 4.
- `BINS`, 256: bins kept per frame (indices 0..BINS-1); 1 ≤ BINS ≤ POINTS.
- `CHAN_W`, 6: channel tag width; must be ≤ DATA_W-1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rstb` in 1: asynchronous, active-low reset.
- `enable` in 1: permits the start of a new capture.
- `chan` in CHAN_W: channel of the frame now streaming; sampled at bin 0.
- `fft_datao_valid` in 1: bin valid strobe.
- `fft_re`, `fft_im` in DATA_W: signed bin value.
- `mag_sel` in 1: 1 selects the magnitude word format; sampled at bin 0.
- `rd_strobe` in 1: host pop request.
- `rd_data` out 2*DATA_W: popped word.
- `rd_valid` out 1: `rd_data` valid, one-cycle pulse.
- `frame_rdy` out 1: a complete frame is held.
- `irq` out 1: one-cycle pulse when `frame_rdy` rises.
- `frame_chan` out CHAN_W: channel of the held frame.
- `ovr_cnt` out 8: dropped-frame count; saturates at 255.

## Operation
- The bin index counter `idx` increments on every `fft_datao_valid` and wraps POINTS-1 → 0. It runs regardless of state. A gap in valid holds `idx`.
- State IDLE, with valid at `idx`=0:
  - If `enable`=1: latch `chan` and `mag_sel`, write bin 0, and go to CAPTURE.
  - Otherwise: ignore the frame, with no count.
- State CAPTURE: write bins while `idx` < BINS and discard bins BINS..POINTS-1. Valid at `idx`=POINTS-1 moves to READY. `enable` falling mid-frame does not abort the capture.
- State READY:
  - `frame_rdy`=1.
  - Each `rd_strobe` pops the word at `rd_ptr` and increments `rd_ptr`.
  - The pop with `rd_ptr`=BINS-1 clears `frame_rdy` and `rd_ptr` and returns to IDLE.
- Valid at `idx`=0 in READY or CAPTURE drops that frame and increments `ovr_cnt`. This includes the cycle of the final pop: the buffer is not free until the next cycle.
- `rd_strobe` while `frame_rdy`=0 is ignored. `rd_valid` stays 0 and the pointer does not move.
- Word formats:
  - Raw: {im, re}.
  - Magnitude: {zero-extended chan to DATA_W-1 bits, mag[DATA_W:0]}, with mag = max(|re|,|im|) + (min(|re|,|im|) >> 1), unsigned. Absolute values are DATA_W bits unsigned, so |−2^(DATA_W−1)| = 2^(DATA_W−1) is exact. The sum fits in DATA_W+1 bits, so no saturation is needed.
- Reset (asynchronous, at any time, including mid-capture or mid-drain):
  - State returns to IDLE, and `idx`, `rd_ptr` and `ovr_cnt` clear to 0.
  - All outputs go to 0.
  - Buffer contents are undefined and not readable.
  - The first valid after reset is treated as `idx`=0.

## Timing
- Write path has one register stage: a bin sampled at edge k (value, or magnitude) is written at edge k+1.
- The last bin sampled at edge k gives `frame_rdy`=1 and `irq`=1 after edge k+1. `irq` is low after edge k+2.
- Read latency is 1: `rd_strobe` sampled at edge r gives `rd_data` and `rd_valid`=1 after edge r. `rd_data` holds its value until the next pop; `rd_valid` is low otherwise.
- Back-to-back strobes yield one word per cycle. A full drain takes BINS cycles minimum.
- `frame_chan` updates at the edge that writes bin 0.

## Configuration
- `FFT_COLLECTOR_MAG_EN` defined: the magnitude estimator and its abs/compare logic are compiled in, and `mag_sel` selects the word format per frame.
- Not defined: the estimator is absent, `mag_sel` is ignored, and every word is raw {im, re}. Timing is identical in both builds.

## Test plan
- Defaults, one frame with re=idx, im=−idx, chan=5, `mag_sel`=0 → `frame_rdy` and a 1-cycle `irq` two edges after bin 511. The 256 pops return {−k, k} for k=0..255, `frame_chan`=5, and `frame_rdy` falls on pop 255.
- Magnitude build, `mag_sel`=1, bin re=−32768, im=−32768 → mag=49152, word={chan, 17'd49152}. Bin re=3, im=−8 → mag=9.
- Second frame starts while the first is held → `ovr_cnt`=1 and the held data is unchanged. A third frame starting on the final-pop cycle is also dropped (`ovr_cnt`=2). The next frame is captured.
- Valid gaps of 0–7 random cycles inside a frame, with `rd_strobe` asserted while empty → identical buffer contents, and no `rd_valid` before `frame_rdy`.
- Assert `rstb` low mid-capture (`idx`=100), then mid-drain (`rd_ptr`=40) → all outputs 0 and IDLE. The next full frame is captured correctly from its bin 0.
